seg7_scan_decoder: RTL and testbench

- Receive side of the team's 7-segment display interface: watches a multiplexed, active-low segment bus plus an active-low digit strobe, and recovers the hex nibble shown on each digit.
- Uses the same segment encoding the display drivers produce (bit 6 = g ... bit 0 = a, 0 = lit).
- Sits between the board's display header (or a looped-back display driver) and self-check/readback logic, giving the design a registered copy of what is physically on the display.

---
 rtl/seg7_scan_decoder.sv | 153 +++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: recovers per-digit hex nibbles from a multiplexed active-low 7-segment bus.
// Define SEG7_BLANK_EN to accept 1111111 as a blank capture and expose blank_mask.
module seg7_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [6:0]                    seg_in,
  input  logic [NUM_DIGITS-1:0]         dig_sel_n,
  input  logic                          err_clr,
  output logic [4*NUM_DIGITS-1:0]       hex_out,
  output logic                          digit_valid,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          digit_err,
  output logic                          frame_done,
  output logic                          err_sticky
`ifdef SEG7_BLANK_EN
  ,output logic [NUM_DIGITS-1:0]        blank_mask
`endif
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;
  state_t state, state_nx;
  logic [6:0] seg_m, s_seg, ref_seg;
  logic [NUM_DIGITS-1:0] sel_m, s_sel, ref_sel, mask, mask_set;
  logic [CW-1:0] cnt, cnt_nx;
  logic one_hot, same, load, cap, code_ok, cap_ok, cap_err;
  logic [3:0] nib;
  logic [IW-1:0] ref_idx;
  // Synchronizers idle at all ones: no strobe, blank segments.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      seg_m <= '1;
      s_seg <= '1;
      sel_m <= '1;
      s_sel <= '1;
    end else begin
      seg_m <= seg_in;
      s_seg <= seg_m;
      sel_m <= dig_sel_n;
      s_sel <= sel_m;
    end
  assign one_hot = $onehot(~s_sel);
  assign same    = (s_seg == ref_seg) && (s_sel == ref_sel);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      ref_seg <= '1;
      ref_sel <= '1;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (load) begin
        ref_seg <= s_seg;
        ref_sel <= s_sel;
      end
    end
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    load     = 1'b0;
    case (state)
      IDLE: begin
        load     = one_hot;
        state_nx = one_hot ? SETTLE : IDLE;
        cnt_nx   = CW'(one_hot);
      end
      SETTLE:
        if (cnt == CW'(STABLE_CYCLES))
          state_nx = HOLD;
        else if (same)
          cnt_nx = cnt + 1'b1;
        else begin
          load     = one_hot;
          state_nx = one_hot ? SETTLE : IDLE;
          cnt_nx   = CW'(one_hot);
        end
      default:
        if (!same) begin
          load     = one_hot;
          state_nx = one_hot ? SETTLE : IDLE;
          cnt_nx   = CW'(one_hot);
        end
    endcase
  end
  // Capture fires once, the cycle after the last stable sample; HOLD blocks repeats.
  assign cap = (state == SETTLE) && (cnt == CW'(STABLE_CYCLES));
  always_comb begin
    nib     = 4'h0;
    code_ok = 1'b1;
    case (ref_seg)
      7'b1000000: nib = 4'h0;
      7'b1111001: nib = 4'h1;
      7'b0100100: nib = 4'h2;
      7'b0110000: nib = 4'h3;
      7'b0011001: nib = 4'h4;
      7'b0010010: nib = 4'h5;
      7'b0000010: nib = 4'h6;
      7'b1111000: nib = 4'h7;
      7'b0000000: nib = 4'h8;
      7'b0011000: nib = 4'h9;
      7'b0001000: nib = 4'hA;
      7'b0000011: nib = 4'hB;
      7'b1000110: nib = 4'hC;
      7'b0100001: nib = 4'hD;
      7'b0000110: nib = 4'hE;
      7'b0001110: nib = 4'hF;
      default:    code_ok = 1'b0;
    endcase
  end
  always_comb begin
    ref_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (!ref_sel[i]) ref_idx = IW'(i);
  end
  assign mask_set = mask | (NUM_DIGITS'(1) << ref_idx);
`ifdef SEG7_BLANK_EN
  logic is_blank;
  assign is_blank = ref_seg == 7'h7f;
  assign cap_ok   = cap && (code_ok || is_blank);
`else
  assign cap_ok   = cap && code_ok;
`endif
  assign cap_err = cap && !cap_ok;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hex_out     <= '0;
      mask        <= '0;
      digit_valid <= 1'b0;
      digit_idx   <= '0;
      digit_err   <= 1'b0;
      frame_done  <= 1'b0;
      err_sticky  <= 1'b0;
`ifdef SEG7_BLANK_EN
      blank_mask  <= '0;
`endif
    end else begin
      digit_valid <= cap_ok;
      digit_err   <= cap_err;
      frame_done  <= cap_ok && (&mask_set);
      err_sticky  <= cap_err || (err_sticky && !err_clr);
      if (cap) digit_idx <= ref_idx;
      if (cap_ok) mask <= (&mask_set) ? '0 : mask_set;
      if (cap && code_ok) hex_out[{ref_idx, 2'b00} +: 4] <= nib;
`ifdef SEG7_BLANK_EN
      if (cap && code_ok) blank_mask[ref_idx] <= 1'b0;
      if (cap && is_blank) blank_mask[ref_idx] <= 1'b1;
`endif
    end
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: directed checks of capture latency, framing, glitch rejection and error handling.
module tb_seg7_scan_decoder;
  logic clk = 1'b0;
  logic rst_n;
  logic [6:0] seg_in;
  logic [3:0] dig_sel_n;
  logic err_clr;
  logic [15:0] hex_out;
  logic digit_valid, digit_err, frame_done, err_sticky;
  logic [1:0] digit_idx;
`ifdef SEG7_BLANK_EN
  logic [3:0] blank_mask;
`endif
  int checks = 0, errors = 0;
  int nv, ne, nf, nf_bad, first_v, first_e, cyc;
  logic [1:0] err_idx, frame_idx;

  seg7_scan_decoder dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .dig_sel_n(dig_sel_n), .err_clr(err_clr),
    .hex_out(hex_out), .digit_valid(digit_valid), .digit_idx(digit_idx), .digit_err(digit_err),
    .frame_done(frame_done), .err_sticky(err_sticky)
`ifdef SEG7_BLANK_EN
    , .blank_mask(blank_mask)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    nv = 0; ne = 0; nf = 0; nf_bad = 0; first_v = -1; first_e = -1; cyc = 0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      if (digit_valid) begin nv++; if (first_v < 0) first_v = cyc; end
      if (digit_err) begin ne++; err_idx = digit_idx; if (first_e < 0) first_e = cyc; end
      if (frame_done) begin nf++; frame_idx = digit_idx; if (!digit_valid) nf_bad++; end
    end
  endtask

  task automatic drive(input logic [3:0] sel, input logic [6:0] seg, input int n);
    dig_sel_n = sel;
    seg_in = seg;
    step(n);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; err_clr = 1'b0; seg_in = 7'b0000000; dig_sel_n = 4'b1110;
    err_idx = '0; frame_idx = '0;
    clr();
    step(3);
    chk("rst_hex", 32'(hex_out), 0);
    chk("rst_valid", 32'(digit_valid), 0);
    chk("rst_idx", 32'(digit_idx), 0);
    chk("rst_err", 32'(digit_err), 0);
    chk("rst_frame", 32'(frame_done), 0);
    chk("rst_sticky", 32'(err_sticky), 0);
    rst_n = 1'b1;
    clr();
    step(10);
    chk("rst_first_valid_cycle", 32'(first_v), 7);
    chk("rst_valid_count", 32'(nv), 1);
    chk("rst_hex_8", 32'(hex_out), 32'h0008);
    chk("rst_no_err", 32'(ne), 0);
    drive(4'b1111, 7'h7f, 3);

    do_reset();
    chk("re_rst_hex", 32'(hex_out), 0);
    clr();
    drive(4'b1110, 7'b0110000, 10);
    chk("single_count", 32'(nv), 1);
    chk("single_cycle", 32'(first_v), 7);
    chk("single_idx", 32'(digit_idx), 0);
    chk("single_hex", 32'(hex_out[3:0]), 3);
    chk("single_no_err", 32'(ne), 0);
    drive(4'b1111, 7'h7f, 3);

    do_reset();
    clr();
    drive(4'b1110, 7'b1111001, 8);
    drive(4'b1101, 7'b0001000, 8);
    drive(4'b1011, 7'b0011000, 8);
    drive(4'b0111, 7'b0001110, 8);
    drive(4'b1111, 7'h7f, 3);
    chk("frame_valid_count", 32'(nv), 4);
    chk("frame_done_count", 32'(nf), 1);
    chk("frame_done_coincident", 32'(nf_bad), 0);
    chk("frame_done_idx", 32'(frame_idx), 3);
    chk("frame_hex", 32'(hex_out), 32'hF9A1);
    chk("frame_mask_clear", 32'(dut.mask), 0);

    clr();
    drive(4'b1011, 7'b0010010, 3);
    drive(4'b1001, 7'b0010010, 10);
    chk("glitch_no_valid", 32'(nv), 0);
    chk("glitch_no_err", 32'(ne), 0);
    chk("glitch_idle", 32'(dut.state), 0);
    drive(4'b1111, 7'h7f, 3);

    clr();
    drive(4'b1101, 7'b1010101, 8);
    chk("inv_err_count", 32'(ne), 1);
    chk("inv_err_cycle", 32'(first_e), 7);
    chk("inv_no_valid", 32'(nv), 0);
    chk("inv_idx", 32'(err_idx), 1);
    chk("inv_sticky", 32'(err_sticky), 1);
    chk("inv_hex_kept", 32'(hex_out), 32'hF9A1);
    drive(4'b1111, 7'h7f, 3);
    drive(4'b1011, 7'b1010101, 6);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    chk("inv2_err_pulse", 32'(digit_err), 1);
    chk("inv2_sticky_wins", 32'(err_sticky), 1);
    step(3);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    chk("clr_sticky", 32'(err_sticky), 0);
    drive(4'b1111, 7'h7f, 3);

    drive(4'b1110, 7'b1111000, 5);
    rst_n = 1'b0;
    step(1);
    chk("midrst_valid", 32'(digit_valid), 0);
    chk("midrst_hex", 32'(hex_out), 0);
    chk("midrst_state", 32'(dut.state), 0);
    drive(4'b1111, 7'h7f, 1);
    rst_n = 1'b1;
    clr();
    step(10);
    chk("midrst_no_pulse", 32'(nv + ne), 0);

    clr();
    drive(4'b0111, 7'b1111111, 8);
`ifdef SEG7_BLANK_EN
    chk("blank_valid", 32'(nv), 1);
    chk("blank_mask3", 32'(blank_mask[3]), 1);
    chk("blank_hex_kept", 32'(hex_out), 0);
`else
    chk("blank_err", 32'(ne), 1);
    chk("blank_err_idx", 32'(err_idx), 3);
    chk("blank_no_valid", 32'(nv), 0);
`endif
    drive(4'b1111, 7'h7f, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
